// File: rtl/lrhls_mac_pkg.sv
// rtl/lrhls_mac_pkg.sv - shared types and helpers for the pipelined signed MAC
// Contents:
//   tag_t       beat tag carried alongside each product (first, last, valid)
//   acc_w       accumulator width from operand widths plus guard bits
//   fits        true when a wide signed value fits in a w-bit signed range
//   sat_narrow  clamps a wide signed value into the w-bit signed range
package lrhls_mac_pkg;

    // Wide working type for range checks; comfortably above any sane ACC_W.
    localparam int WIDE_W = 128;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic first;
        logic last;
        logic valid;
    } tag_t;

    function automatic int acc_w(input int a, input int b, input int g);
        return a + b + g;
    endfunction

    function automatic wide_t wide_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic logic fits(input wide_t v, input int w);
        return (v <= wide_max(w)) && (v >= (-wide_max(w) - wide_t'(1)));
    endfunction

    function automatic wide_t sat_narrow(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = wide_max(w);
        lo = -hi - wide_t'(1);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/lrhls_mac_pipe_if.sv
// rtl/lrhls_mac_pipe_if.sv - input beat stream and result stream of the MAC pipe
// Signals:
//   in_valid/in_ready        beat handshake; din0, din1, in_first, in_last ride with it
//   out_valid/out_ready      result handshake; dout, out_ovf ride with it
// Modports: master = producer/consumer side, slave = the MAC itself.
interface lrhls_mac_pipe_if #(
    parameter int DIN0_W = 18,
    parameter int DIN1_W = 18,
    parameter int DOUT_W = 36
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DIN0_W-1:0] din0;
    logic signed [DIN1_W-1:0] din1;
    logic                     in_first;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DOUT_W-1:0] dout;
    logic                     out_ovf;

    modport master (
        output in_valid, din0, din1, in_first, in_last, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );

    modport slave (
        input  in_valid, din0, din1, in_first, in_last, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );
endinterface

// File: rtl/lrhls_mac_mul_stage.sv
// rtl/lrhls_mac_mul_stage.sv - NUM_STAGE-deep enabled signed product pipeline with beat tags
// Ports:
//   clk, rst_n   clock and active-low reset (async assert)
//   en           advance every register this cycle
//   a, b         signed operands
//   tag_in       tag of the beat presented this cycle (valid already qualified by handshake)
//   prod         full-precision product at the last register
//   tag_out      tag matching prod
module lrhls_mac_mul_stage
    import lrhls_mac_pkg::*;
#(
    parameter int DIN0_W    = 18,
    parameter int DIN1_W    = 18,
    parameter int NUM_STAGE = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic signed [DIN0_W-1:0]        a,
    input  logic signed [DIN1_W-1:0]        b,
    input  tag_t                            tag_in,
    output logic signed [DIN0_W+DIN1_W-1:0] prod,
    output tag_t                            tag_out
);
    localparam int PROD_W = DIN0_W + DIN1_W;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod_now;

    logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
    tag_t                     tag_q  [NUM_STAGE];

    // Explicit sign extension keeps the multiply at full product width.
    assign a_ext    = {{DIN1_W{a[DIN0_W-1]}}, a};
    assign b_ext    = {{DIN0_W{b[DIN1_W-1]}}, b};
    assign prod_now = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (en) begin
            prod_q[0] <= prod_now;
            tag_q[0]  <= tag_in;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign prod    = prod_q[NUM_STAGE-1];
    assign tag_out = tag_q[NUM_STAGE-1];

endmodule

// File: rtl/lrhls_mac_pipe.sv
// rtl/lrhls_mac_pipe.sv - pipelined signed multiply-accumulate with first/last framing
// Ports:
//   ap_clk     clock
//   ap_rst_n   asynchronous active-low reset, released synchronously inside
//   bus        lrhls_mac_pipe_if.slave: beat stream in, result stream out
// Build option: LRHLS_MAC_SAT_EN clamps dout on overflow; otherwise dout wraps.
module lrhls_mac_pipe
    import lrhls_mac_pkg::*;
#(
    parameter int DIN0_W    = 18,
    parameter int DIN1_W    = 18,
    parameter int GUARD_W   = 4,
    parameter int DOUT_W    = 36,
    parameter int NUM_STAGE = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    lrhls_mac_pipe_if.slave  bus
);
    localparam int PROD_W = DIN0_W + DIN1_W;
    localparam int ACC_W  = acc_w(DIN0_W, DIN1_W, GUARD_W);

    logic [1:0]               rst_sync_q;
    logic                     rst_n_int;
    logic                     advance;
    logic                     in_ready;
    tag_t                     tag_in;
    tag_t                     tag_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_next;
    wide_t                    acc_wide;
    logic signed [DOUT_W-1:0] dout_next;
    logic                     ovf_next;
    logic                     out_valid_q;
    logic signed [DOUT_W-1:0] dout_q;
    logic                     ovf_q;
    logic                     emit;

    // Reset asserts immediately but releases only on an ap_clk edge, so every
    // downstream flop leaves reset in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // The whole pipe moves as one; a held result freezes every stage.
    assign advance  = !out_valid_q || bus.out_ready;
    assign in_ready = advance && rst_n_int;

    assign tag_in.first = bus.in_first;
    assign tag_in.last  = bus.in_last;
    assign tag_in.valid = bus.in_valid && in_ready;

    lrhls_mac_mul_stage #(
        .DIN0_W    (DIN0_W),
        .DIN1_W    (DIN1_W),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk     (ap_clk),
        .rst_n   (rst_n_int),
        .en      (advance),
        .a       (bus.din0),
        .b       (bus.din1),
        .tag_in  (tag_in),
        .prod    (prod),
        .tag_out (tag_s)
    );

    assign prod_ext = {{GUARD_W{prod[PROD_W-1]}}, prod};
    assign acc_next = tag_s.first ? prod_ext : (acc_q + prod_ext);
    assign acc_wide = {{(WIDE_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};
    assign ovf_next = !fits(acc_wide, DOUT_W);
    assign emit     = tag_s.valid && tag_s.last;

`ifdef LRHLS_MAC_SAT_EN
    wide_t sat_wide;
    assign sat_wide  = sat_narrow(acc_wide, DOUT_W);
    assign dout_next = sat_wide[DOUT_W-1:0];
`else
    assign dout_next = acc_next[DOUT_W-1:0];
`endif

    // Bubbles leave the accumulator untouched.
    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            acc_q <= '0;
        end else if (advance && tag_s.valid) begin
            acc_q <= acc_next;
        end
    end

    // Output register: cleared on handshake unless a new result lands the same cycle.
    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= emit;
            if (emit) begin
                dout_q <= dout_next;
                ovf_q  <= ovf_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_lrhls_mac_pipe.sv
// tb/tb_lrhls_mac_pipe.sv - directed self-checking bench for lrhls_mac_pipe
module tb_lrhls_mac_pipe;

    logic ap_clk;
    logic ap_rst_n;
    int   n_err;
    int   n_chk;

    logic signed [35:0] q_dout [$];
    logic               q_ovf  [$];

    int    a3    [8];
    int    b3    [8];
    longint exp3 [8];
    int    idx;
    logic  acc;

    lrhls_mac_pipe_if #(.DIN0_W(18), .DIN1_W(18), .DOUT_W(36)) bus ();

    lrhls_mac_pipe dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Record every completed output handshake; sampled mid-cycle.
    always @(negedge ap_clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_dout.push_back(bus.dout);
            q_ovf.push_back(bus.out_ovf);
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input int a, input int b, input logic f, input logic l);
        int k;
        bus.in_valid = 1'b1;
        bus.din0     = 18'(a);
        bus.din1     = 18'(b);
        bus.in_first = f;
        bus.in_last  = l;
        #1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            step();
            k++;
        end
        chk("beat_accept", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_outputs(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (q_dout.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, q_dout.size(), n);
    endtask

    initial begin
        n_err        = 0;
        n_chk        = 0;
        ap_rst_n     = 1'b0;
        bus.in_valid = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_ovf", bus.out_ovf, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        ap_rst_n = 1'b1;
        repeat (3) step();
        chk("rel_in_ready", bus.in_ready, 1);

        // 1: single product, latency NUM_STAGE+1
        bus.out_ready = 1'b1;
        beat(-131072, -131072, 1'b1, 1'b1);
        chk("t1_valid_t1", bus.out_valid, 0);
        step();
        chk("t1_valid_t2", bus.out_valid, 0);
        step();
        chk("t1_valid_t3", bus.out_valid, 1);
        chk("t1_dout", bus.dout, 64'sd17179869184);
        chk("t1_ovf", bus.out_ovf, 0);
        repeat (3) step();
        q_dout.delete();
        q_ovf.delete();

        // 2: four-beat sum -> -98
        beat(3, 5, 1'b1, 1'b0);
        beat(-2, 7, 1'b0, 1'b0);
        beat(100, -1, 1'b0, 1'b0);
        beat(1, 1, 1'b0, 1'b1);
        wait_outputs("t2_count", 1, 20);
        repeat (4) step();
        chk("t2_count_after", q_dout.size(), 1);
        if (q_dout.size() > 0) begin
            chk("t2_dout", q_dout[0], -98);
            chk("t2_ovf", q_ovf[0], 0);
        end
        q_dout.delete();
        q_ovf.delete();

        // 3: back-to-back singles with a 5-cycle output stall
        for (int i = 0; i < 8; i++) begin
            a3[i]   = 3 * i - 5;
            b3[i]   = 7 - 2 * i;
            exp3[i] = longint'(a3[i]) * longint'(b3[i]);
        end
        idx = 0;
        for (int c = 0; c < 80 && idx < 8; c++) begin
            bus.in_valid  = 1'b1;
            bus.din0      = 18'(a3[idx]);
            bus.din1      = 18'(b3[idx]);
            bus.in_first  = 1'b1;
            bus.in_last   = 1'b1;
            bus.out_ready = !(c >= 5 && c < 10);
            #1;
            if (c >= 5 && c < 10) begin
                chk("t3_stall_in_ready", bus.in_ready, 0);
                chk("t3_stall_valid", bus.out_valid, 1);
                if (q_dout.size() < 8) begin
                    chk("t3_stall_dout", bus.dout, exp3[q_dout.size()]);
                end
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge ap_clk);
            #1;
            if (acc) begin
                idx++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        wait_outputs("t3_count", 8, 30);
        repeat (3) step();
        chk("t3_count_after", q_dout.size(), 8);
        for (int i = 0; i < 8 && i < q_dout.size(); i++) begin
            chk($sformatf("t3_dout_%0d", i), q_dout[i], exp3[i]);
        end
        q_dout.delete();
        q_ovf.delete();

        // 4: overflow of the 36-bit result
        beat(-131072, -131072, 1'b1, 1'b0);
        beat(-131072, -131072, 1'b0, 1'b1);
        wait_outputs("t4_count", 1, 20);
        if (q_dout.size() > 0) begin
`ifdef LRHLS_MAC_SAT_EN
            chk("t4_dout", q_dout[0], 64'sd34359738367);
`else
            chk("t4_dout", q_dout[0], -64'sd34359738368);
`endif
            chk("t4_ovf", q_ovf[0], 1);
        end
        repeat (3) step();
        q_dout.delete();
        q_ovf.delete();

        // 5: async reset mid-sum while a result is held
        bus.out_ready = 1'b0;
        beat(2, 3, 1'b1, 1'b1);
        beat(10, 10, 1'b1, 1'b0);
        beat(5, 5, 1'b0, 1'b0);
        chk("t5_held_valid", bus.out_valid, 1);
        chk("t5_held_dout", bus.dout, 6);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_dout", bus.dout, 0);
        chk("t5_rst_ovf", bus.out_ovf, 0);
        chk("t5_rst_in_ready", bus.in_ready, 0);
        ap_rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("t5_rel_in_ready", bus.in_ready, 1);
        beat(4, -3, 1'b1, 1'b0);
        beat(-2, -2, 1'b0, 1'b1);
        wait_outputs("t5_count", 1, 20);
        repeat (3) step();
        chk("t5_count_after", q_dout.size(), 1);
        if (q_dout.size() > 0) begin
            chk("t5_dout", q_dout[0], -8);
        end
        q_dout.delete();
        q_ovf.delete();

        // 6: first reissued before last restarts the sum
        beat(10, 10, 1'b1, 1'b0);
        beat(3, 3, 1'b1, 1'b0);
        beat(2, 2, 1'b0, 1'b1);
        wait_outputs("t6_count", 1, 20);
        repeat (3) step();
        chk("t6_count_after", q_dout.size(), 1);
        if (q_dout.size() > 0) begin
            chk("t6_dout", q_dout[0], 13);
            chk("t6_ovf", q_ovf[0], 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
